// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: multi-cycle shift-add multiplier retiring DIGIT multiplier bits per cycle, signed/unsigned, valid/ready on both sides.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N  = WIDTH / DIGIT;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % (DIGIT < 1 ? 1 : DIGIT)) != 0) begin : g_bad_digit
    $error("seq_shift_add_multiplier: DIGIT must be in 1..WIDTH and divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0]    a_sh, acc, sum, res;
  logic [WIDTH-1:0] b_sh, a_mag, b_mag;
  logic [CW-1:0]    cnt;
  logic             neg, last;
  always_comb begin
    last      = cnt == CW'(N - 1);
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    sum       = acc + a_sh * PW'(b_sh[DIGIT-1:0]);
    res       = neg ? -sum : sum;
    in_ready  = state == IDLE && !rst;
    out_valid = state == DONE;
    busy      = state != IDLE;
    state_n   = rst ? IDLE :
                state == IDLE ? (in_valid ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // The multiplicand shifts left and the multiplier right, so each cycle's slice lands at DIGIT*count.
  always_ff @(posedge clk) begin
    state <= state_n;
    if (rst) begin
      product <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh <= {{WIDTH{1'b0}}, a_mag};
      b_sh <= b_mag;
      neg  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= sum;
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh >> DIGIT;
      cnt  <= cnt + 1'b1;
      if (last) product <= res;
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: scoreboard bench with random and directed operations over three parameter sets.
module tb_seq_shift_add_multiplier;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, in_valid = 0, signed_op = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [7:0] a = 0, b = 0;
  logic [15:0] product;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic [15:0] p; int c;} exp_t;
  exp_t sb[$];
  logic ov_q = 0, or_q = 0;
  bit done4 = 0, done16 = 0;
  seq_shift_add_multiplier dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_op(signed_op), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy));
  logic r4 = 1, iv4 = 0, s4 = 0, ir4, ov4, bz4;
  logic [7:0] a4 = 0, b4 = 0;
  logic [15:0] p4;
  seq_shift_add_multiplier #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(r4), .in_valid(iv4),
    .in_ready(ir4), .a(a4), .b(b4), .signed_op(s4), .out_valid(ov4), .out_ready(1'b1),
    .product(p4), .busy(bz4));
  logic r16 = 1, iv16 = 0, s16 = 0, ir16, ov16, bz16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;
  seq_shift_add_multiplier #(.WIDTH(16), .DIGIT(2)) dut16 (.clk(clk), .rst(r16), .in_valid(iv16),
    .in_ready(ir16), .a(a16), .b(b16), .signed_op(s16), .out_valid(ov16), .out_ready(1'b1),
    .product(p16), .busy(bz16));
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Plain integer arithmetic on sign-interpreted operands, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(logic [63:0] x, logic [63:0] y, bit s, int w);
    longint sx = longint'(x), sy = longint'(y);
    if (s && x[w-1]) sx -= longint'(1) << w;
    if (s && y[w-1]) sy -= longint'(1) << w;
    return 64'(sx * sy) & ((64'd1 << (2 * w)) - 1);
  endfunction
  always @(negedge clk) begin
    if (rst) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{16'(ref_mul(64'(a), 64'(b), signed_op, 8)), cyc});
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_vs_busy", in_ready, !busy);
      chk("in_ready_and_out_valid", in_ready && out_valid, 0);
      if (ov_q && !or_q) chk("valid_held", out_valid, 1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out actual=%0h required=none", product);
        end else begin
          if (!ov_q) chk("latency", 64'(cyc - sb[0].c), 9);
          chk("product", product, sb[0].p);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
    ov_q = out_valid && !rst;
    or_q = out_ready;
  end
  task automatic issue(logic [7:0] x, logic [7:0] y, bit s);
    @(posedge clk); #2;
    in_valid = 1; a = x; b = y; signed_op = s;
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    chk("accept_timeout", in_ready, 1);
    @(posedge clk); #2;
    in_valid = 0;
  endtask
  task automatic wait_out();
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    chk("out_timeout", out_valid, 1);
  endtask
  task automatic run4(logic [7:0] x, logic [7:0] y, bit s);
    int c0;
    @(posedge clk); #2;
    iv4 = 1; a4 = x; b4 = y; s4 = s;
    @(negedge clk);
    for (int i = 0; i < 20 && !ir4; i++) @(negedge clk);
    c0 = cyc;
    @(posedge clk); #2;
    iv4 = 0; a4 = ~x;
    @(negedge clk);
    for (int i = 0; i < 20 && !ov4; i++) @(negedge clk);
    chk("d4_latency", 64'(cyc - c0), 3);
    chk("d4_product", p4, ref_mul(64'(x), 64'(y), s, 8));
  endtask
  task automatic run16(logic [15:0] x, logic [15:0] y, bit s);
    int c0;
    @(posedge clk); #2;
    iv16 = 1; a16 = x; b16 = y; s16 = s;
    @(negedge clk);
    for (int i = 0; i < 40 && !ir16; i++) @(negedge clk);
    c0 = cyc;
    @(posedge clk); #2;
    iv16 = 0; b16 = ~y;
    @(negedge clk);
    for (int i = 0; i < 40 && !ov16; i++) @(negedge clk);
    chk("d16_latency", 64'(cyc - c0), 9);
    chk("d16_product", p16, ref_mul(64'(x), 64'(y), s, 16));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2 r4 = 0;
    run4(8'd200, 8'd3, 0);
    run4(8'h80, 8'h80, 1);
    repeat (20) run4(8'($urandom), 8'($urandom), 1'($urandom));
    done4 = 1;
  end
  initial begin
    repeat (2) @(posedge clk);
    #2 r16 = 0;
    run16(16'hFFFF, 16'hFFFF, 0);
    run16(16'h8000, 16'h8000, 1);
    repeat (20) run16(16'($urandom), 16'($urandom), 1'($urandom));
    done16 = 1;
  end
  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    in_valid = 1; a = 8'd5; b = 8'd7;
    @(negedge clk);
    chk("in_ready_during_rst", in_ready, 0);
    @(posedge clk); #2;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_in_ready", in_ready, 1);
    issue(8'd255, 8'd255, 0);
    wait_out();
    chk("ff_x_ff", product, 16'hFE01);
    issue(8'h80, 8'h80, 1);
    issue(8'hFF, 8'h7F, 1);
    issue(8'h80, 8'h01, 1);
    wait_out();
    chk("m128_x_1", product, 16'hFF80);
    @(posedge clk); #2 out_ready = 0;
    issue(8'h12, 8'h34, 0);
    wait_out();
    repeat (5) @(negedge clk);
    chk("bp_product", product, 16'h03A8);
    @(posedge clk); #2 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    issue(8'h55, 8'h66, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_product", product, 0);
    issue(8'd13, 8'd11, 0);
    wait_out();
    chk("13_x_11", product, 16'd143);
    repeat (600) begin
      @(posedge clk); #2;
      in_valid = $urandom_range(0, 3) != 0;
      a = 8'($urandom); b = 8'($urandom); signed_op = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      if ($urandom_range(0, 7) == 0) b = $urandom_range(0, 1) ? 8'h00 : 8'h80;
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #2;
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 0);
    for (int i = 0; i < 2000 && !(done4 && done16); i++) @(posedge clk);
    chk("aux_done", done4 && done16, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Multi-cycle, parametrised shift-add multiplier. Successor to the 8x8 single-cycle combinational array multiplier used in the matrix-multiply datapath.
- Retires DIGIT multiplier bits per cycle, supports per-operation signed/unsigned mode, and uses valid/ready handshakes on both sides so MAC lanes can trade area for latency.
- Sits between the operand fetch stage and the accumulator.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- DIGIT, 1, multiplier bits consumed per cycle. Legal range 1..WIDTH with WIDTH % DIGIT == 0; any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, signed_op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_op  input  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result.
- busy  output  1  high in BUSY and DONE states.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: while rst is sampled high, the next state is IDLE with product=0, out_valid=0, busy=0. in_ready is 0 during any cycle rst is high.
- Reset mid-operation (BUSY or DONE): the operation is discarded, no out_valid is produced, and the block is back in IDLE on the next cycle.
- Let N = WIDTH/DIGIT.
- FSM state IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready at the clock edge. This latches a, b and signed_op, clears the accumulator and the digit counter, and moves to BUSY.
- FSM state BUSY:
  - in_ready=0; in_valid is ignored.
  - Each cycle adds (|a| * current DIGIT-bit slice of |b|) << (DIGIT*count) into a 2*WIDTH accumulator, starting from the LSBs, then increments count.
  - After slice N-1, the sign fix-up is applied in that same edge and the FSM moves to DONE.
- FSM state DONE:
  - out_valid=1 and product holds the result.
  - On out_valid&&out_ready, move to IDLE; out_valid is low from the next cycle.
  - product keeps its last value until the next result.
  - While out_ready=0, product and out_valid are held stable indefinitely.
- Latency: if the handshake completes in cycle c0, out_valid is first high in cycle c0+N+1 (N+1 = 9 for defaults; 2 for DIGIT=WIDTH).
- Throughput: one operation per N+2 cycles with out_ready tied high. in_ready is never high in the same cycle as out_valid.
- Arithmetic, unsigned mode: product = a*b exactly; no overflow is possible in 2*WIDTH bits.
- Arithmetic, signed mode:
  - Magnitudes are taken at accept; |most-negative| is held in WIDTH unsigned bits.
  - The product is negated in two's complement at completion when sign(a) xor sign(b).
  - Result is exact in 2*WIDTH bits, e.g. (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- Zero operands: no early termination; latency is always N+1.
- Simultaneous rst and in_valid: reset wins and the operation is not accepted.

Test Plan:
- Unsigned default params: a=255, b=255, signed_op=0, handshake in cycle 0 -> out_valid first high in cycle 9 with product=16'hFE01; in_ready low in cycles 1-9.
- Signed: a=8'h80, b=8'h80 -> product=16'h4000. Then a=8'hFF, b=8'h7F -> product=16'hFF81. Then a=8'h80, b=8'h01 -> product=16'hFF80.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> product and out_valid stable all 5 cycles. Raise out_ready -> out_valid low next cycle, in_ready high.
- Reset mid-op: assert rst in cycle 4 of BUSY -> next cycle out_valid=0, busy=0, product=0. A new op 13*11 then yields 143 with full latency 9.
- DIGIT=4, WIDTH=8: a=200, b=3 -> out_valid 3 cycles after accept, product=600. Repeat with WIDTH=16, DIGIT=2, a=16'hFFFF, b=16'hFFFF unsigned -> product=32'hFFFE0001 after 9 cycles.
- in_valid held high with changing a/b throughout BUSY/DONE -> only the first-accepted operands affect product; the next accept occurs only after IDLE is re-entered.
